// File: rtl/dac_wave_gen_pkg.sv
// -----------------------------------------------------------------------------
// dac_wave_gen_pkg
//   Shared types and constants for the dual-channel DAC waveform generator.
//   Contents:
//     wave_e      waveform select (SAW, TRI, SQR, DC), encoded as cfg_wave
//     MIDSCALE    offset-binary code for 0 V (14'h2000)
//     UNITY_AMP   gain code for a x1.0 scale (128)
//     DATA_W_DEF  default DAC sample width
//     PHASE_W_DEF default phase accumulator width
// -----------------------------------------------------------------------------
package dac_wave_gen_pkg;

   localparam int unsigned DATA_W_DEF  = 14;
   localparam int unsigned PHASE_W_DEF = 32;

   typedef enum logic [1:0] {
      SAW = 2'd0,
      TRI = 2'd1,
      SQR = 2'd2,
      DC  = 2'd3
   } wave_e;

   localparam logic [13:0] MIDSCALE  = 14'h2000;
   localparam logic [7:0]  UNITY_AMP = 8'd128;

endpackage

// File: rtl/dac_wave_gen_if.sv
// -----------------------------------------------------------------------------
// dac_wave_gen_if
//   Configuration bus and DAC sample outputs of dac_wave_gen.
//   master : drives ch_en and the cfg_* write request, observes outputs
//   slave  : the generator (returns cfg_ready, daN_data, daN_wrap)
//   Signals:
//     ch_en[1:0]         per-channel enable (bit0 = DA1, bit1 = DA2)
//     cfg_valid/ready    configuration write handshake
//     cfg_ch             target channel (0 = DA1, 1 = DA2)
//     cfg_ftw            frequency tuning word
//     cfg_wave           waveform select (wave_e encoding)
//     cfg_amp            unsigned gain, 128 = unity
//     daN_data           registered offset-binary samples
//     daN_wrap           pulse aligned with the sample following a phase wrap
// -----------------------------------------------------------------------------
interface dac_wave_gen_if #(
   parameter int unsigned DATA_W  = 14,
   parameter int unsigned PHASE_W = 32
) ();

   logic [1:0]         ch_en;
   logic               cfg_valid;
   logic               cfg_ready;
   logic               cfg_ch;
   logic [PHASE_W-1:0] cfg_ftw;
   logic [1:0]         cfg_wave;
   logic [7:0]         cfg_amp;
   logic [DATA_W-1:0]  da1_data;
   logic [DATA_W-1:0]  da2_data;
   logic               da1_wrap;
   logic               da2_wrap;

   modport master (
      output ch_en, cfg_valid, cfg_ch, cfg_ftw, cfg_wave, cfg_amp,
      input  cfg_ready, da1_data, da2_data, da1_wrap, da2_wrap
   );

   modport slave (
      input  ch_en, cfg_valid, cfg_ch, cfg_ftw, cfg_wave, cfg_amp,
      output cfg_ready, da1_data, da2_data, da1_wrap, da2_wrap
   );

endinterface

// File: rtl/dac_wave_gen_wave_chan.sv
// -----------------------------------------------------------------------------
// wave_chan
//   One DAC channel: phase accumulator, pending/active configuration and a
//   three-stage shape -> multiply -> saturate/offset datapath.
//   Ports:
//     clk, rst     sample clock, asynchronous active-high reset
//     en_i         channel enable; when low phase is held at 0, output midscale
//     cfg_we_i     accepted configuration write for this channel
//     cfg_*_i      configuration values loaded into the pending register
//     pend_o       pending configuration waiting to become active
//     data_o       offset-binary sample
//     wrap_o       pulse aligned with the sample following a phase wrap
// -----------------------------------------------------------------------------
module wave_chan
   import dac_wave_gen_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned PHASE_W = PHASE_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               cfg_we_i,
   input  logic [PHASE_W-1:0] cfg_ftw_i,
   input  wave_e              cfg_wave_i,
   input  logic [7:0]         cfg_amp_i,
   output logic               pend_o,
   output logic [DATA_W-1:0]  data_o,
   output logic               wrap_o
);

   // product width: DATA_W signed sample times 9-bit zero-extended gain
   localparam int unsigned PW = DATA_W + 9;
   localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] SMAX = ~MID;

   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASE_W-1:0] ftw_q, ftw_d, pftw_q, pftw_d;
   wave_e              wave_q, wave_d, pwave_q, pwave_d;
   logic [7:0]         amp_q, amp_d, pamp_q, pamp_d;
   logic               pend_q, pend_d;
   logic [PHASE_W:0]   sum;
   logic               wrap;

   logic [DATA_W-1:0]  p, u, s_d, s_q;
   logic [7:0]         amp1_q;
   logic signed [PW-1:0] prod_d, prod_q, y;
   logic [DATA_W-1:0]  sat, data_d, data_q;
   logic [3:0]         wpipe_q, wpipe_d;

   // Phase accumulator and configuration hand-over. A write is only accepted
   // while nothing is pending, so load and apply never collide; the wrap that
   // coincides with acceptance sees pend_q still low and is skipped.
   always_comb begin
      sum     = {1'b0, phase_q} + {1'b0, ftw_q};
      wrap    = en_i & sum[PHASE_W];
      phase_d = en_i ? sum[PHASE_W-1:0] : '0;
      ftw_d   = ftw_q;
      wave_d  = wave_q;
      amp_d   = amp_q;
      pftw_d  = pftw_q;
      pwave_d = pwave_q;
      pamp_d  = pamp_q;
      pend_d  = pend_q;
      if (pend_q && (!en_i || wrap)) begin
         ftw_d  = pftw_q;
         wave_d = pwave_q;
         amp_d  = pamp_q;
         pend_d = 1'b0;
      end
      if (cfg_we_i) begin
         pftw_d  = cfg_ftw_i;
         pwave_d = cfg_wave_i;
         pamp_d  = cfg_amp_i;
         pend_d  = 1'b1;
      end
   end

   // Shaping: subtracting midscale from a DATA_W-bit code is an MSB flip.
   always_comb begin
      p   = phase_q[PHASE_W-1 -: DATA_W];
      u   = p[DATA_W-1] ? ~{p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};
      s_d = '0;
      if (en_i) begin
         case (wave_q)
            SAW:     s_d = p ^ MID;
            TRI:     s_d = u ^ MID;
            SQR:     s_d = p[DATA_W-1] ? MID : SMAX;
            default: s_d = '0;
         endcase
      end
   end

   always_comb begin
      prod_d = $signed({{(PW-DATA_W){s_q[DATA_W-1]}}, s_q})
             * $signed({{(PW-8){1'b0}}, amp1_q});
      y      = prod_q >>> 7;
      // in range when all bits above the sample sign agree with it
      if (y[PW-1:DATA_W-1] == '0 || y[PW-1:DATA_W-1] == '1) begin
         sat = y[DATA_W-1:0];
      end else begin
         sat = y[PW-1] ? MID : SMAX;
      end
      data_d  = sat ^ MID;
      wpipe_d = {wpipe_q[2:0], wrap};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
         ftw_q   <= '0;
         wave_q  <= SAW;
         amp_q   <= UNITY_AMP;
         pftw_q  <= '0;
         pwave_q <= SAW;
         pamp_q  <= UNITY_AMP;
         pend_q  <= 1'b0;
         s_q     <= '0;
         amp1_q  <= UNITY_AMP;
         prod_q  <= '0;
         data_q  <= MID;
         wpipe_q <= '0;
      end else begin
         phase_q <= phase_d;
         ftw_q   <= ftw_d;
         wave_q  <= wave_d;
         amp_q   <= amp_d;
         pftw_q  <= pftw_d;
         pwave_q <= pwave_d;
         pamp_q  <= pamp_d;
         pend_q  <= pend_d;
         s_q     <= s_d;
         amp1_q  <= amp_q;
         prod_q  <= prod_d;
         data_q  <= data_d;
         wpipe_q <= wpipe_d;
      end
   end

   assign pend_o = pend_q;
   assign data_o = data_q;
   assign wrap_o = wpipe_q[3];

endmodule

// File: rtl/dac_wave_gen.sv
// -----------------------------------------------------------------------------
// dac_wave_gen
//   Dual-channel DDS waveform generator feeding two offset-binary DACs.
//   Ports:
//     clk_125  sample clock
//     reset    asynchronous active-high reset
//     bus      dac_wave_gen_if.slave: ch_en, cfg handshake, DA1/DA2 samples
//              and wrap pulses
// -----------------------------------------------------------------------------
module dac_wave_gen
   import dac_wave_gen_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned PHASE_W = PHASE_W_DEF
) (
   input  logic          clk_125,
   input  logic          reset,
   dac_wave_gen_if.slave bus
);

   logic [1:0] pend;
   logic [1:0] we;

   always_comb begin
      we             = '0;
      we[bus.cfg_ch] = bus.cfg_valid & ~pend[bus.cfg_ch];
   end

   assign bus.cfg_ready = ~pend[bus.cfg_ch];

   wave_chan #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) u_da1 (
      .clk        (clk_125),
      .rst        (reset),
      .en_i       (bus.ch_en[0]),
      .cfg_we_i   (we[0]),
      .cfg_ftw_i  (bus.cfg_ftw),
      .cfg_wave_i (wave_e'(bus.cfg_wave)),
      .cfg_amp_i  (bus.cfg_amp),
      .pend_o     (pend[0]),
      .data_o     (bus.da1_data),
      .wrap_o     (bus.da1_wrap)
   );

   wave_chan #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) u_da2 (
      .clk        (clk_125),
      .rst        (reset),
      .en_i       (bus.ch_en[1]),
      .cfg_we_i   (we[1]),
      .cfg_ftw_i  (bus.cfg_ftw),
      .cfg_wave_i (wave_e'(bus.cfg_wave)),
      .cfg_amp_i  (bus.cfg_amp),
      .pend_o     (pend[1]),
      .data_o     (bus.da2_data),
      .wrap_o     (bus.da2_wrap)
   );

endmodule

// File: tb/tb_dac_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_dac_wave_gen
//   Self-checking bench for dac_wave_gen: a table of gain/waveform vectors plus
//   directed sequences for ramp, square saturation, triangle span, handshake
//   timing, frozen phase and mid-run reset.
// -----------------------------------------------------------------------------
module tb_dac_wave_gen;
   import dac_wave_gen_pkg::*;

   logic clk_125 = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   dac_wave_gen_if #(.DATA_W(14), .PHASE_W(32)) bus ();

   dac_wave_gen #(.DATA_W(14), .PHASE_W(32)) dut (
      .clk_125 (clk_125),
      .reset   (reset),
      .bus     (bus)
   );

   always #4 clk_125 = ~clk_125;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]  wave;
      logic [7:0]  amp;
      logic [13:0] exp0;   // phase 0
      logic [13:0] exp1;   // phase 2^30
      logic [13:0] exp2;   // phase 2^31
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_125);
      @(negedge clk_125);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.ch_en     = 2'b00;
      bus.cfg_valid = 1'b0;
      steps(2);
      reset = 1'b0;
      step();
   endtask

   task automatic write_cfg(input logic ch, input logic [31:0] ftw,
                            input logic [1:0] wave, input logic [7:0] amp);
      bus.cfg_ch    = ch;
      bus.cfg_ftw   = ftw;
      bus.cfg_wave  = wave;
      bus.cfg_amp   = amp;
      bus.cfg_valid = 1'b1;
      step();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic ready_of(input logic ch, output logic r);
      bus.cfg_ch = ch;
      #1;
      r = bus.cfg_ready;
   endtask

   task automatic wait_wrap(input logic ch, input int maxc, output int n);
      logic w;
      n = 0;
      do begin
         step();
         n++;
         w = ch ? bus.da2_wrap : bus.da1_wrap;
      end while (w !== 1'b1 && n < maxc);
      chk($sformatf("wrap seen ch%0d", ch), {31'b0, w}, 32'd1);
   endtask

   initial begin
      logic        r;
      int          n, bad, wraps;
      logic [13:0] exp, pp, uu, mn, mx;
      logic [13:0] ee[3];
      int          s, y;

      vecs[0]  = '{SQR, 8'd128, 14'h3FFF, 14'h3FFF, 14'h0000};
      vecs[1]  = '{SQR, 8'd64,  14'h2FFF, 14'h2FFF, 14'h1000};
      vecs[2]  = '{SQR, 8'd0,   14'h2000, 14'h2000, 14'h2000};
      vecs[3]  = '{SQR, 8'd1,   14'h203F, 14'h203F, 14'h1FC0};
      vecs[4]  = '{SQR, 8'd129, 14'h3FFF, 14'h3FFF, 14'h0000};
      vecs[5]  = '{SAW, 8'd128, 14'h0000, 14'h1000, 14'h2000};
      vecs[6]  = '{SAW, 8'd64,  14'h1000, 14'h1800, 14'h2000};
      vecs[7]  = '{SAW, 8'd1,   14'h1FC0, 14'h1FE0, 14'h2000};
      vecs[8]  = '{SAW, 8'd255, 14'h0000, 14'h0020, 14'h2000};
      vecs[9]  = '{TRI, 8'd128, 14'h0000, 14'h2000, 14'h3FFF};
      vecs[10] = '{TRI, 8'd200, 14'h0000, 14'h2000, 14'h3FFF};
      vecs[11] = '{DC,  8'd255, 14'h2000, 14'h2000, 14'h2000};

      reset         = 1'b1;
      bus.ch_en     = 2'b00;
      bus.cfg_valid = 1'b0;
      bus.cfg_ch    = 1'b0;
      bus.cfg_ftw   = '0;
      bus.cfg_wave  = 2'd0;
      bus.cfg_amp   = 8'd0;

      // reset state
      steps(2);
      chk("reset da1_data", {18'b0, bus.da1_data}, {18'b0, MIDSCALE});
      chk("reset da2_data", {18'b0, bus.da2_data}, {18'b0, MIDSCALE});
      chk("reset wraps", {30'b0, bus.da1_wrap, bus.da2_wrap}, 32'd0);
      ready_of(1'b0, r); chk("reset ready ch0", {31'b0, r}, 32'd1);
      ready_of(1'b1, r); chk("reset ready ch1", {31'b0, r}, 32'd1);
      @(negedge clk_125);
      reset = 1'b0;
      steps(3);
      chk("post-reset da1_data", {18'b0, bus.da1_data}, 32'h2000);
      chk("post-reset da2_data", {18'b0, bus.da2_data}, 32'h2000);

      // table: shape/gain/saturation at phases 0, 2^30, 2^31
      for (int unsigned i = 0; i < 12; i++) begin
         do_reset();
         write_cfg(1'b0, 32'h4000_0000, vecs[i].wave, vecs[i].amp);
         step();
         ready_of(1'b0, r);
         chk($sformatf("vec%0d applied while disabled", i), {31'b0, r}, 32'd1);
         bus.ch_en = 2'b01;
         steps(3);
         chk($sformatf("vec%0d sample0", i), {18'b0, bus.da1_data}, {18'b0, vecs[i].exp0});
         step();
         chk($sformatf("vec%0d sample1", i), {18'b0, bus.da1_data}, {18'b0, vecs[i].exp1});
         step();
         chk($sformatf("vec%0d sample2", i), {18'b0, bus.da1_data}, {18'b0, vecs[i].exp2});
      end

      // ch0 saw ramp, one code per cycle, full wrap
      do_reset();
      write_cfg(1'b0, 32'h0004_0000, SAW, 8'd128);
      step();
      bus.ch_en = 2'b01;
      bad = 0; wraps = 0;
      for (int k = 0; k < 16390; k++) begin
         step();
         exp = (k < 2) ? 14'h2000 : 14'((k - 2) & 16'h3FFF);
         if (bus.da1_data !== exp) bad++;
         if (bus.da1_wrap === 1'b1) wraps++;
         if (bus.da1_wrap !== ((k >= 3) && ((k - 2) % 16384 == 0))) bad++;
         if (k == 2)     chk("saw first sample", {18'b0, bus.da1_data}, 32'h0000);
         if (k == 3)     chk("saw second sample", {18'b0, bus.da1_data}, 32'h0001);
         if (k == 16385) chk("saw top", {18'b0, bus.da1_data}, 32'h3FFF);
         if (k == 16386) chk("saw wrap data", {18'b0, bus.da1_data}, 32'h0000);
         if (k == 16386) chk("saw wrap pulse", {31'b0, bus.da1_wrap}, 32'd1);
      end
      chk("saw ramp bad samples", bad, 0);
      chk("saw wrap count", wraps, 1);

      // ch1 square, amp 255 saturates to both rails
      do_reset();
      write_cfg(1'b1, 32'h1000_0000, SQR, 8'd255);
      step();
      bus.ch_en = 2'b10;
      for (int k = 0; k < 42; k++) begin
         step();
         if (k < 2) begin
            exp = 14'h2000;
            chk($sformatf("sqr k%0d wrap", k), {31'b0, bus.da2_wrap}, 32'd0);
         end else begin
            exp = (((k - 2) / 8) % 2 == 0) ? 14'h3FFF : 14'h0000;
            chk($sformatf("sqr k%0d wrap", k), {31'b0, bus.da2_wrap},
                {31'b0, ((k - 2) > 0 && (k - 2) % 16 == 0)});
         end
         chk($sformatf("sqr k%0d data", k), {18'b0, bus.da2_data}, {18'b0, exp});
      end
      chk("sqr leaves da1 idle", {18'b0, bus.da1_data}, 32'h2000);

      // ch0 triangle, amp 64: half-scale span around midscale
      do_reset();
      write_cfg(1'b0, 32'h0100_0000, TRI, 8'd64);
      step();
      bus.ch_en = 2'b01;
      steps(2);
      bad = 0; mn = 14'h3FFF; mx = 14'h0000;
      for (int k = 0; k < 256; k++) begin
         step();
         pp = 14'((k * 64) & 16'h3FFF);
         uu = pp[13] ? ~{pp[12:0], 1'b0} : {pp[12:0], 1'b0};
         s  = int'(uu) - 8192;
         y  = (s * 64) >>> 7;
         exp = 14'(y + 8192);
         if (bus.da1_data !== exp) bad++;
         if (bus.da1_data < mn) mn = bus.da1_data;
         if (bus.da1_data > mx) mx = bus.da1_data;
         if (k == 64)  chk("tri quarter", {18'b0, bus.da1_data}, 32'h2000);
         if (k == 128) chk("tri peak", {18'b0, bus.da1_data}, 32'h2FFF);
         if (k == 192) chk("tri three-quarter", {18'b0, bus.da1_data}, 32'h1FFF);
      end
      chk("tri bad samples", bad, 0);
      chk("tri min", {18'b0, mn}, 32'h1000);
      chk("tri max", {18'b0, mx}, 32'h2FFF);

      // handshake: mid-period write applies at next wrap
      do_reset();
      write_cfg(1'b0, 32'h1000_0000, SAW, 8'd128);
      step();
      bus.ch_en = 2'b01;
      wait_wrap(1'b0, 40, n);
      steps(4);
      write_cfg(1'b0, 32'h2000_0000, SAW, 8'd128);
      ready_of(1'b0, r); chk("pending ready ch0", {31'b0, r}, 32'd0);
      ready_of(1'b1, r); chk("pending ready ch1", {31'b0, r}, 32'd1);
      bus.cfg_ch = 1'b0;
      wait_wrap(1'b0, 40, n); chk("wrap before apply", n, 11);
      wait_wrap(1'b0, 40, n); chk("period after apply", n, 8);
      ready_of(1'b0, r); chk("ready after apply", {31'b0, r}, 32'd1);

      // acceptance on the wrap edge defers the update one period
      steps(4);
      write_cfg(1'b0, 32'h1000_0000, SAW, 8'd128);
      wait_wrap(1'b0, 40, n); chk("coincident wrap", n, 3);
      ready_of(1'b0, r); chk("still pending after coincident wrap", {31'b0, r}, 32'd0);
      wait_wrap(1'b0, 40, n); chk("old period kept", n, 8);
      wait_wrap(1'b0, 40, n); chk("new period", n, 16);

      // FTW = 0 freezes phase; pending applies only via an enable toggle
      do_reset();
      bus.ch_en = 2'b01;
      write_cfg(1'b0, 32'h1000_0000, SQR, 8'd128);
      steps(20);
      ready_of(1'b0, r); chk("frozen pending ready", {31'b0, r}, 32'd0);
      chk("frozen data", {18'b0, bus.da1_data}, 32'h0000);
      bus.ch_en = 2'b00;
      step();
      bus.ch_en = 2'b01;
      step();
      ready_of(1'b0, r); chk("toggle applied ready", {31'b0, r}, 32'd1);
      steps(2);
      chk("toggle applied data", {18'b0, bus.da1_data}, 32'h3FFF);

      // reset mid-ramp discards the pending configuration
      do_reset();
      write_cfg(1'b0, 32'h0004_0000, SAW, 8'd128);
      step();
      bus.ch_en = 2'b01;
      steps(100);
      write_cfg(1'b0, 32'h0010_0000, SQR, 8'd255);
      steps(3);
      bus.cfg_ch = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async reset da1", {18'b0, bus.da1_data}, 32'h2000);
      chk("async reset wrap", {31'b0, bus.da1_wrap}, 32'd0);
      chk("async reset ready", {31'b0, bus.cfg_ready}, 32'd1);
      @(negedge clk_125);
      reset = 1'b0;
      steps(2);
      chk("post-reset latency", {18'b0, bus.da1_data}, 32'h2000);
      step();
      chk("first sample after reset", {18'b0, bus.da1_data}, 32'h0000);
      wraps = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (bus.da1_wrap === 1'b1) wraps++;
      end
      chk("no wrap after reset", wraps, 0);
      chk("old pending not applied", {18'b0, bus.da1_data}, 32'h0000);
      ready_of(1'b0, r); chk("ready after reset", {31'b0, r}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dac_wave_gen.md
DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

Interface
REQ-001 Parameter DATA_W, default 14: DAC sample width, offset-binary.
REQ-002 Parameter PHASE_W, default 32: phase accumulator width.
REQ-003 clk_125  in  1  sample clock; DAC samples are consumed on the opposite edge downstream.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ch_en  in  2  per-channel enable; bit0 = DA1, bit1 = DA2.
REQ-006 cfg_valid  in  1  configuration write request.
REQ-007 cfg_ready  out  1  configuration can be accepted for the channel on cfg_ch.
REQ-008 cfg_ch  in  1  target channel; 0 = DA1, 1 = DA2.
REQ-009 cfg_ftw  in  PHASE_W  frequency tuning word.
REQ-010 cfg_wave  in  2  waveform select: 0 saw, 1 triangle, 2 square, 3 DC.
REQ-011 cfg_amp  in  8  unsigned gain; 128 = unity.
REQ-012 da1_data, da2_data  out  DATA_W each  registered offset-binary samples.
REQ-013 da1_wrap, da2_wrap  out  1 each  one-cycle pulse aligned with the output sample that follows a phase wrap.

Function
REQ-014 Each enabled channel SHALL add its active FTW to its phase every clk_125 cycle, modulo 2^PHASE_W; a wrap is the carry-out of that add.
REQ-015 A disabled channel SHALL hold phase at 0 and SHALL output 14'h2000.
REQ-016 Shaping SHALL use the top 14 phase bits p[31:18] to form a signed 14-bit value s:
- saw: s = p - 8192.
- triangle: u = phase[31] ? ~{phase[30:18],0} : {phase[30:18],0}; s = u - 8192.
- square: s = phase[31] ? -8192 : +8191.
- DC: s = 0.
REQ-017 Scaling SHALL be y = (s * amp) >>> 7, arithmetic shift, full-precision product.
REQ-018 y SHALL saturate to the range [-8192, +8191]; output = saturated y + 8192, i.e. MSB inverted.
REQ-019 Pipeline latency SHALL be 3 cycles from a phase-register update to the corresponding daN_data change: shape -> multiply -> saturate/offset, all registered.
REQ-020 A handshake SHALL occur when cfg_valid and cfg_ready are both 1 at a rising edge; the accepted values load the pending register of cfg_ch.
REQ-021 cfg_ready SHALL equal NOT pending_flag[cfg_ch] (combinational on cfg_ch).
REQ-022 A pending configuration SHALL become active on the first wrap of its channel that occurs after acceptance; the active configuration then clears pending_flag.
REQ-023 A wrap in the same cycle as acceptance SHALL NOT apply the new configuration; it applies at the next wrap.
REQ-024 A pending configuration for a disabled channel SHALL apply on the cycle after acceptance.
REQ-025 FTW = 0 on an enabled channel SHALL freeze phase, and a pending configuration SHALL then never apply.
- Exception: a falling-then-rising ch_en re-applies it via REQ-024.
REQ-026 Channels SHALL be independent; simultaneous wraps on both channels SHALL each apply their own pending configuration.

Reset
REQ-027 While reset is 1, and asynchronously on its assertion:
- phase = 0, active FTW = 0, wave = saw, amp = 128;
- pending flags cleared;
- pipeline registers cleared to s = 0;
- daN_data = 14'h2000, daN_wrap = 0, cfg_ready = 1.
REQ-028 Reset asserted mid-operation SHALL discard any pending configuration; the first valid sample appears 3 cycles after deassertion.

Structure
REQ-029 A shared package SHALL hold:
- the waveform enum (SAW, TRI, SQR, DC);
- MIDSCALE = 14'h2000;
- UNITY_AMP = 128;
- the DATA_W and PHASE_W defaults.
REQ-030 One sub-module, wave_chan, SHALL implement the phase accumulator, pending/active registers and 3-stage datapath for one channel; dac_wave_gen SHALL instantiate it twice and multiplex cfg_ready.

Verification
REQ-031 Reset -> both outputs 14'h2000, cfg_ready = 1, no wrap pulses.
REQ-032 Ch0 saw, FTW = 2^18, amp 128, enabled -> da1_data increments by 1 per cycle from 14'h0000 after latency, reaches 14'h3FFF, then wraps to 0 with da1_wrap.
REQ-033 Ch1 square, FTW = 2^28, amp 255 -> da2_data alternates 14'h0000 / 14'h3FFF every 8 cycles (saturation exercised).
REQ-034 Ch0 triangle, FTW = 2^24, amp 64 -> peak-to-peak is about 8192 codes, centred on 14'h2000.
REQ-035 Second write to ch0 before its wrap -> cfg_ready is 0 for cfg_ch = 0 and 1 for cfg_ch = 1.
- The new FTW takes effect only at the next wrap.
- An acceptance coinciding with a wrap defers the update by one period.
REQ-036 Reset pulsed mid-ramp with a pending configuration -> outputs return to 14'h2000 immediately; the old pending configuration is never applied.
